// File: rtl/axis_rd_interface_fc_if.sv
// AXI-Stream beat channel from the DMA (MM2S) into the receive FIFO.
interface axis_rd_interface_fc_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_rd_interface_fc.sv
// AXIS receive FIFO with frame-length enforcement and tkeep checking.
// Optional AXIS_RD_STATS_EN adds popped-frame and popped-beat counters.
module axis_rd_interface_fc #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    FIFO_AW    = 4,
  parameter logic [DATA_WIDTH/8-1:0] KEEP_MASK = 'h03,
  parameter int                    MAX_BEATS  = 16
) (
  input  logic                    core_clk,
  input  logic                    rst,
  axis_rd_interface_fc_if.slave   s_axis,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_last,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    almost_empty,
  output logic [FIFO_AW:0]        level,
  output logic                    frame_done,
  output logic                    keep_err,
  output logic                    len_err,
  input  logic                    err_clr
`ifdef AXIS_RD_STATS_EN
  ,
  output logic [31:0]             frame_cnt,
  output logic [31:0]             beat_cnt_total
`endif
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(MAX_BEATS + 1);

  typedef enum logic {S_IDLE, S_FRAME} state_t;

  logic [DATA_WIDTH:0]  mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     level_next;
  logic [CW-1:0]        beat_cnt;
  state_t               state;
  logic                 push, pop, forced, last_flag, keep_bad;

  assign push      = s_axis.tvalid && s_axis.tready;
  assign pop       = dout_valid && dout_ready;
  assign keep_bad  = s_axis.tkeep != KEEP_MASK;
  assign dout      = mem[rd_ptr][DATA_WIDTH-1:0];
  assign dout_last = dout_valid && mem[rd_ptr][DATA_WIDTH];

  // A frame that hits MAX_BEATS without tlast is closed on that beat.
  always_comb begin
    forced = 1'b0;
    if (push && !s_axis.tlast) begin
      if (state == S_IDLE) forced = (MAX_BEATS == 1);
      else                 forced = (beat_cnt == CW'(MAX_BEATS - 1));
    end
  end
  assign last_flag  = s_axis.tlast || forced;
  assign level_next = level + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};

  always_ff @(posedge core_clk) begin
    if (push) mem[wr_ptr] <= {last_flag, s_axis.tdata};
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      s_axis.tready <= 1'b0;
      dout_valid    <= 1'b0;
      almost_empty  <= 1'b1;
      frame_done    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level         <= level_next;
      s_axis.tready <= level_next < (FIFO_AW+1)'(DEPTH);
      dout_valid    <= level_next != '0;
      almost_empty  <= level_next <= (FIFO_AW+1)'(1);
      frame_done    <= pop && dout_last;
    end
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
    end else if (push) begin
      if (last_flag) begin
        state    <= S_IDLE;
        beat_cnt <= '0;
      end else begin
        state    <= S_FRAME;
        beat_cnt <= (state == S_IDLE) ? CW'(1) : beat_cnt + CW'(1);
      end
    end
  end

  // Set events take priority over a simultaneous clear.
  always_ff @(posedge core_clk) begin
    if (rst) begin
      keep_err <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      if (push && keep_bad) keep_err <= 1'b1;
      else if (err_clr)     keep_err <= 1'b0;
      if (forced)           len_err  <= 1'b1;
      else if (err_clr)     len_err  <= 1'b0;
    end
  end

`ifdef AXIS_RD_STATS_EN
  always_ff @(posedge core_clk) begin
    if (rst) begin
      frame_cnt      <= '0;
      beat_cnt_total <= '0;
    end else begin
      if (pop && dout_last) frame_cnt <= frame_cnt + 32'd1;
      if (pop)              beat_cnt_total <= beat_cnt_total + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_axis_rd_interface_fc.sv
// Bench for axis_rd_interface_fc: directed scenarios plus random traffic vs a queue model.
module tb_axis_rd_interface_fc;
  localparam int DW = 64, AW = 4, DEPTH = 16, MAXB = 16;
  localparam logic [7:0] KM = 8'h03;

  logic          core_clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] dout;
  logic          dout_last, dout_valid, dout_ready, almost_empty;
  logic          frame_done, keep_err, len_err, err_clr;
  logic [AW:0]   level;
`ifdef AXIS_RD_STATS_EN
  logic [31:0]   frame_cnt, beat_cnt_total;
`endif

  axis_rd_interface_fc_if #(.DATA_WIDTH(DW)) s_axis ();

  axis_rd_interface_fc #(.DATA_WIDTH(DW), .FIFO_AW(AW), .KEEP_MASK(KM), .MAX_BEATS(MAXB)) dut (
    .core_clk(core_clk), .rst(rst), .s_axis(s_axis),
    .dout(dout), .dout_last(dout_last), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .almost_empty(almost_empty), .level(level), .frame_done(frame_done),
    .keep_err(keep_err), .len_err(len_err), .err_clr(err_clr)
`ifdef AXIS_RD_STATS_EN
    , .frame_cnt(frame_cnt), .beat_cnt_total(beat_cnt_total)
`endif
  );

  always #5 core_clk = ~core_clk;

  int vecs = 0, errs = 0;

  // Reference model: FIFO contents as a queue of {last, data}.
  logic [DW:0] q[$];
  logic [DW:0] obs[$];
  bit m_rdy, m_fd, m_kerr, m_lerr;
  int m_cnt, fd_obs;

  // Advance one clock: record what the DUT hands out, then update the model.
  task automatic step();
    bit push, pop, lf, kset, lset;
    if (dout_valid && dout_ready) obs.push_back({dout_last, dout});
    if (frame_done) fd_obs++;
    push = s_axis.tvalid && m_rdy;
    pop  = (q.size() != 0) && dout_ready;
    if (rst) begin
      q.delete(); m_rdy = 0; m_fd = 0; m_kerr = 0; m_lerr = 0; m_cnt = 0;
    end else begin
      m_fd = pop && q[0][DW];
      if (pop) void'(q.pop_front());
      kset = push && (s_axis.tkeep != KM);
      lset = push && !s_axis.tlast && (m_cnt + 1 == MAXB);
      if (push) begin
        lf = s_axis.tlast || lset;
        q.push_back({lf, s_axis.tdata});
        m_cnt = lf ? 0 : m_cnt + 1;
      end
      m_kerr = kset ? 1'b1 : (err_clr ? 1'b0 : m_kerr);
      m_lerr = lset ? 1'b1 : (err_clr ? 1'b0 : m_lerr);
      m_rdy  = q.size() < DEPTH;
    end
    @(posedge core_clk);
    @(negedge core_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [DW-1:0] d, input bit last, input logic [7:0] keep);
    bit acc;
    s_axis.tdata = d; s_axis.tlast = last; s_axis.tkeep = keep; s_axis.tvalid = 1'b1;
    acc = 0;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = m_rdy;
      step();
    end
    s_axis.tvalid = 1'b0;
    if (!acc) begin
      errs++;
      $display("FAIL send_timeout: beat %h not accepted within 200 cycles, required accept", d);
    end
  endtask

  task automatic clear_errs();
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(2);
    vecs++; if (s_axis.tready !== 1'b0) begin errs++; $display("FAIL rst_tready: got %b want 0", s_axis.tready); end
    vecs++; if (dout_valid !== 1'b0) begin errs++; $display("FAIL rst_dout_valid: got %b want 0", dout_valid); end
    vecs++; if (level !== '0) begin errs++; $display("FAIL rst_level: got %0d want 0", level); end
    vecs++; if ({keep_err, len_err, frame_done} !== 3'b000) begin errs++; $display("FAIL rst_flags: got %b want 000", {keep_err, len_err, frame_done}); end
    rst = 1'b0; idle(1);
    vecs++; if (s_axis.tready !== 1'b1) begin errs++; $display("FAIL rel_tready: got %b want 1", s_axis.tready); end
    vecs++; if (almost_empty !== 1'b1 || level !== '0) begin errs++; $display("FAIL rel_empty: got ae=%b lvl=%0d want ae=1 lvl=0", almost_empty, level); end
  endtask

  task automatic test_frame3();
    obs.delete(); fd_obs = 0; dout_ready = 1'b1;
    send(64'h11, 0, KM); send(64'h22, 0, KM); send(64'h33, 1, KM);
    idle(4);
    vecs++;
    if (obs.size() != 3) begin errs++; $display("FAIL f3_count: got %0d beats want 3", obs.size()); end
    else if (obs[0] !== {1'b0, 64'h11} || obs[1] !== {1'b0, 64'h22} || obs[2] !== {1'b1, 64'h33}) begin
      errs++; $display("FAIL f3_seq: got %h %h %h want 0..11 0..22 1..33", obs[0], obs[1], obs[2]);
    end
    vecs++; if (fd_obs != 1) begin errs++; $display("FAIL f3_frame_done: got %0d pulses want 1", fd_obs); end
    vecs++; if (keep_err !== 1'b0 || len_err !== 1'b0) begin errs++; $display("FAIL f3_errs: got k=%b l=%b want 0 0", keep_err, len_err); end
  endtask

  task automatic test_full();
    obs.delete(); dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(64'(i + 'h100), 0, KM);
    vecs++; if (level !== 5'd16) begin errs++; $display("FAIL full_level: got %0d want 16", level); end
    vecs++; if (s_axis.tready !== 1'b0) begin errs++; $display("FAIL full_tready: got %b want 0", s_axis.tready); end
    s_axis.tdata = 64'h110; s_axis.tlast = 0; s_axis.tkeep = KM; s_axis.tvalid = 1'b1;
    idle(3);
    s_axis.tvalid = 1'b0;
    vecs++; if (level !== 5'd16 || q.size() != 16) begin errs++; $display("FAIL full_hold: got %0d want 16", level); end
    dout_ready = 1'b1;
    for (int i = 16; i < 20; i++) send(64'(i + 'h100), i == 19, KM);
    idle(24);
    vecs++;
    if (obs.size() != 20) begin errs++; $display("FAIL full_count: got %0d beats want 20", obs.size()); end
    else for (int i = 0; i < 20; i++)
      if (obs[i] !== {(i == 15 || i == 19), 64'(i + 'h100)}) begin
        errs++; $display("FAIL full_order: beat %0d got %h want %h", i, obs[i], {(i == 15 || i == 19), 64'(i + 'h100)});
      end
    vecs++; if (level !== '0 || dout_valid !== 1'b0) begin errs++; $display("FAIL full_drain: got lvl=%0d v=%b want 0 0", level, dout_valid); end
    clear_errs();
  endtask

  task automatic test_len();
    obs.delete(); dout_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(64'(i + 'h200), 0, KM);
    send(64'h211, 1, KM);
    idle(4);
    vecs++; if (len_err !== 1'b1) begin errs++; $display("FAIL len_set: got %b want 1", len_err); end
    vecs++;
    if (obs.size() != 18) begin errs++; $display("FAIL len_count: got %0d beats want 18", obs.size()); end
    else for (int i = 0; i < 18; i++)
      if (obs[i][DW] !== (i == 15 || i == 17)) begin
        errs++; $display("FAIL len_last: beat %0d got last=%b want %b", i, obs[i][DW], (i == 15 || i == 17));
      end
    clear_errs();
    vecs++; if (len_err !== 1'b0) begin errs++; $display("FAIL len_clr: got %b want 0", len_err); end
  endtask

  task automatic test_keep();
    obs.delete(); dout_ready = 1'b1;
    send(64'hAB, 1, 8'hFF);
    idle(3);
    vecs++; if (keep_err !== 1'b1) begin errs++; $display("FAIL keep_set: got %b want 1", keep_err); end
    vecs++; if (obs.size() != 1 || obs[0] !== {1'b1, 64'hAB}) begin errs++; $display("FAIL keep_data: got %0d beats want 1 beat 0xAB", obs.size()); end
    err_clr = 1'b1; send(64'hCD, 1, 8'h01); err_clr = 1'b0;
    vecs++; if (keep_err !== 1'b1) begin errs++; $display("FAIL keep_clr_race: got %b want 1", keep_err); end
    idle(3); clear_errs();
    vecs++; if (keep_err !== 1'b0) begin errs++; $display("FAIL keep_clr: got %b want 0", keep_err); end
  endtask

  task automatic test_reset_mid();
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(64'(i + 'h300), 0, KM);
    rst = 1'b1; idle(1);
    vecs++; if (level !== '0 || dout_valid !== 1'b0 || dout_last !== 1'b0) begin errs++; $display("FAIL mid_rst: got lvl=%0d v=%b l=%b want 0 0 0", level, dout_valid, dout_last); end
    vecs++; if (s_axis.tready !== 1'b0) begin errs++; $display("FAIL mid_tready: got %b want 0", s_axis.tready); end
    rst = 1'b0; idle(1);
    obs.delete(); fd_obs = 0; dout_ready = 1'b1;
    for (int i = 0; i < 13; i++) send(64'(i + 'h400), i == 12, KM);
    idle(4);
    vecs++;
    if (obs.size() != 13) begin errs++; $display("FAIL mid_count: got %0d beats want 13", obs.size()); end
    else for (int i = 0; i < 13; i++)
      if (obs[i] !== {(i == 12), 64'(i + 'h400)}) begin
        errs++; $display("FAIL mid_seq: beat %0d got %h want %h", i, obs[i], {(i == 12), 64'(i + 'h400)});
      end
    vecs++; if (fd_obs != 1 || len_err !== 1'b0) begin errs++; $display("FAIL mid_frame: got fd=%0d len=%b want 1 0", fd_obs, len_err); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      s_axis.tvalid = ($urandom_range(9) < 7);
      s_axis.tdata  = {$urandom, $urandom};
      s_axis.tlast  = ($urandom_range(5) == 0);
      s_axis.tkeep  = ($urandom_range(15) == 0) ? 8'($urandom) : KM;
      dout_ready    = (c % 200 < 100) ? ($urandom_range(9) < 3) : ($urandom_range(9) < 8);
      err_clr       = ($urandom_range(19) == 0);
      vecs++; if (s_axis.tready !== m_rdy) begin errs++; $display("FAIL rnd_tready c%0d: got %b want %b", c, s_axis.tready, m_rdy); end
      vecs++; if (dout_valid !== (q.size() != 0)) begin errs++; $display("FAIL rnd_valid c%0d: got %b want %b", c, dout_valid, q.size() != 0); end
      if (q.size() != 0) begin
        vecs++; if ({dout_last, dout} !== q[0]) begin errs++; $display("FAIL rnd_head c%0d: got %h want %h", c, {dout_last, dout}, q[0]); end
      end
      vecs++; if (level !== (AW+1)'(q.size()) || almost_empty !== (q.size() <= 1)) begin errs++; $display("FAIL rnd_level c%0d: got %0d ae=%b want %0d", c, level, almost_empty, q.size()); end
      vecs++; if (frame_done !== m_fd) begin errs++; $display("FAIL rnd_fd c%0d: got %b want %b", c, frame_done, m_fd); end
      vecs++; if (keep_err !== m_kerr || len_err !== m_lerr) begin errs++; $display("FAIL rnd_errs c%0d: got k=%b l=%b want k=%b l=%b", c, keep_err, len_err, m_kerr, m_lerr); end
      step();
    end
    s_axis.tvalid = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0; s_axis.tkeep = KM;
    dout_ready = 1'b0; err_clr = 1'b0;
    @(negedge core_clk);
    test_reset();
    test_frame3();
    test_full();
    test_len();
    test_keep();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/axis_rd_interface_fc.md
Name: axis_rd_interface_fc

Overview:
AXI-Stream slave (MM2S side) receiving beats from the DMA and buffering them in a single-clock FIFO for the core, with ready/valid flow control toward the core. It is the receive-direction counterpart of the core's AXIS write path. Tracks frame boundaries (tlast), enforces a maximum frame length, and flags unexpected tkeep patterns. One clock domain: DMA and core share core_clk.

Parameters:
DATA_WIDTH, 64, tdata/dout width in bits
FIFO_AW, 4, FIFO address width; DEPTH = 2**FIFO_AW beats (16)
KEEP_MASK, 8'h03, expected tkeep on every beat (DATA_WIDTH/8 bits)
MAX_BEATS, 16, maximum beats per frame before a forced frame end (>=1)

Ports:
core_clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  DATA_WIDTH  stream data
s_axis_tkeep  in  DATA_WIDTH/8  byte enables
s_axis_tlast  in  1  end of frame
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  slave ready, registered
dout  out  DATA_WIDTH  FIFO head data (show-ahead)
dout_last  out  1  head beat ends a frame
dout_valid  out  1  head is valid (FIFO not empty)
dout_ready  in  1  core pops head when dout_valid&&dout_ready
almost_empty  out  1  level <= 1
level  out  FIFO_AW+1  beats currently stored (0..DEPTH)
frame_done  out  1  one-cycle pulse when a last-flagged beat is popped
keep_err  out  1  sticky: accepted beat had tkeep != KEEP_MASK
len_err  out  1  sticky: frame reached MAX_BEATS without tlast
err_clr  in  1  clears keep_err and len_err

Behaviour:
- Reset (rst=1 at core_clk edge): wr/rd pointers, level=0, s_axis_tready=0, dout_valid=0, dout_last=0, frame_done=0, keep_err=0, len_err=0, FSM=S_IDLE, beat_cnt=0. dout is don't-care while dout_valid=0. Reset mid-frame discards all stored beats and the partial frame; no error is raised.
- s_axis_tready: registered; next value = (level_next < DEPTH) and not in reset. First high on the cycle after rst deasserts.
- push = s_axis_tvalid && s_axis_tready; pop = dout_valid && dout_ready.
- FIFO entry = {last_flag, tdata}. Push-to-dout_valid latency: 1 cycle (written at edge, visible after it). dout/dout_last read combinationally from mem[rd_ptr].
- level_next = level + push - pop; simultaneous push+pop leaves level unchanged. Pointers wrap modulo DEPTH.
- Full: after the DEPTH-th beat is stored, tready goes low in the same edge; a pop while full re-raises tready the next cycle. No write is ever lost or overwritten.
- Empty: dout_valid=0; dout_ready ignored; no pointer movement.
- Frame FSM (input side, advances on push only):
  S_IDLE: push -> beat_cnt=1; if tlast or MAX_BEATS==1 -> stay S_IDLE, beat_cnt=0; else -> S_FRAME.
  S_FRAME: push -> beat_cnt+1; if tlast -> S_IDLE, beat_cnt=0; else if beat_cnt+1 == MAX_BEATS -> store last_flag=1, set len_err, S_IDLE, beat_cnt=0 (forced boundary; subsequent beats start a new frame).
  Stored last_flag = s_axis_tlast OR forced end.
- keep_err set on any push with s_axis_tkeep != KEEP_MASK; data is still stored.
- err_clr clears both sticky flags; a set event in the same cycle as err_clr wins (flag stays 1).
- frame_done: registered, high for exactly the cycle after a pop with dout_last=1.
- almost_empty and level: registered, updated from level_next.

Optional Feature:
AXIS_RD_STATS_EN: adds output frame_cnt [31:0] (frames popped, i.e. frame_done count) and beat_cnt_total [31:0] (total pops); both reset to 0, wrap at 2^32, unaffected by err_clr. Without the macro, these ports and counters do not exist.

Test Plan:
- Reset release, no traffic -> tready=1 one cycle after rst falls; dout_valid=0, level=0, almost_empty=1.
- 3-beat frame (tdata 0x11,0x22,0x33; tlast on 3rd; tkeep=8'h03), dout_ready=1 -> dout sequence 0x11,0x22,0x33, dout_last only on 0x33, single frame_done pulse, no errors.
- dout_ready=0, stream 20 beats -> 16 accepted, tready low after 16th, level=16; raise dout_ready -> remaining 4 accepted in order, no loss or duplication.
- 17 beats with no tlast, MAX_BEATS=16 -> beat 16 stored with last_flag=1, len_err=1; beat 17 opens a new frame; err_clr pulse -> len_err=0.
- Beat with tkeep=8'hFF -> keep_err=1, data still delivered; err_clr asserted in the same cycle as a further bad beat -> keep_err stays 1.
- rst asserted with 5 beats stored mid-frame -> next cycle level=0, dout_valid=0, tready=0, FSM S_IDLE; new frame after release received cleanly.
